dift_trap_ctrl: RTL and testbench

Sequences DIFT policy violations from the tag check unit into the core's exception path. Latches the first violation with its trap type and PC, then holds a request to the core controller until acknowledged. After acknowledgement it stays armed-off until software clears it. Keeps saturating per-type violation counters and a dropped-event counter for the CSR file, and supports a log-only mode in which violations are counted but never raised.

---
 rtl/dift_trap_ctrl_pkg.sv | 30 +++
 rtl/dift_sat_counter.sv | 34 +++
 rtl/dift_trap_ctrl.sv | 111 +++++++++++
 tb/tb_dift_trap_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dift_trap_ctrl_pkg.sv
//==============================================================================
// Module   : riscv_defines (package)
// Brief    : Shared DIFT trap types and trap-controller state encoding.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package riscv_defines;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    EXEC = 3'd1,
    JALR = 3'd2,
    BRAN = 3'd3,
    STOR = 3'd4,
    LOAD = 3'd5
  } dift_trap_t;

  typedef logic [1:0] dift_trap_state_t;

  localparam dift_trap_state_t IDLE    = 2'd0;
  localparam dift_trap_state_t REQ     = 2'd1;
  localparam dift_trap_state_t HANDLER = 2'd2;

  // Slot 0 is the drop counter, slots 1..5 follow the dift_trap_t encoding.
  localparam int unsigned DIFT_NUM_CNT = 6;

endpackage

`default_nettype wire

// File: rtl/dift_sat_counter.sv
//==============================================================================
// Module   : dift_sat_counter
// Brief    : Saturating event counter with synchronous clear (clear wins).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dift_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] c_max = '1;

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: rtl/dift_trap_ctrl.sv
//==============================================================================
// Module   : dift_trap_ctrl
// Brief    : Routes DIFT tag-check violations into the core exception path
//            and keeps saturating per-type and dropped-event counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dift_trap_ctrl
  import riscv_defines::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trap_i,
  input  dift_trap_t           trap_type_i,
  input  logic [31:0]          pc_i,
  input  logic                 trap_en_i,
  input  logic                 trap_ack_i,
  input  logic                 trap_clr_i,
  input  logic [2:0]           cnt_sel_i,
  input  logic                 cnt_clr_i,
  output logic                 trap_req_o,
  output dift_trap_t           trap_cause_o,
  output logic [31:0]          trap_pc_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] cnt_rdata_o
);

  dift_trap_state_t r_state;
  dift_trap_t       r_cause;
  logic [31:0]      r_pc;

  logic                 w_event;
  logic [2:0]           w_type;
  logic [DIFT_NUM_CNT-1:0] w_cnt_inc;
  logic [CNT_WIDTH-1:0] w_cnt [DIFT_NUM_CNT];

  assign w_type  = trap_type_i;
  assign w_event = trap_i && (trap_type_i != NONE);

  // Clear beats ack when both arrive in REQ: software abort takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cause <= NONE;
      r_pc    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_event && trap_en_i) begin
            r_state <= REQ;
            r_cause <= trap_type_i;
            r_pc    <= pc_i;
          end
        end
        REQ: begin
          if (trap_clr_i) begin
            r_state <= IDLE;
          end else if (trap_ack_i) begin
            r_state <= HANDLER;
          end
        end
        HANDLER: begin
          if (trap_clr_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar k = 0; k < DIFT_NUM_CNT; k++) begin : g_cnt
      if (k == 0) begin : g_drop
        assign w_cnt_inc[k] = w_event && (r_state != IDLE);
      end else begin : g_type
        assign w_cnt_inc[k] = w_event && (w_type == 3'(k));
      end

      dift_sat_counter #(
        .WIDTH (CNT_WIDTH)
      ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr_i),
        .inc_i (w_cnt_inc[k]),
        .cnt_o (w_cnt[k])
      );
    end
  endgenerate

  always_comb begin
    cnt_rdata_o = '0;
    for (int k = 0; k < DIFT_NUM_CNT; k++) begin
      if (cnt_sel_i == 3'(k)) begin
        cnt_rdata_o = w_cnt[k];
      end
    end
  end

  assign trap_req_o   = (r_state == REQ);
  assign busy_o       = (r_state != IDLE);
  assign trap_cause_o = r_cause;
  assign trap_pc_o    = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_dift_trap_ctrl.sv
//==============================================================================
// Module   : tb_dift_trap_ctrl
// Brief    : Directed, table-driven self-checking bench for dift_trap_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dift_trap_ctrl;
  import riscv_defines::*;

  localparam int CW = 4;

  typedef struct {
    logic        rst;
    logic        trap;
    dift_trap_t  ttype;
    logic [31:0] pc;
    logic        en;
    logic        ack;
    logic        clr;
    logic [2:0]  sel;
    logic        cclr;
    logic        e_req;
    dift_trap_t  e_cause;
    logic [31:0] e_pc;
    logic        e_busy;
    logic [CW-1:0] e_cnt;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           trap_i;
  dift_trap_t     trap_type_i;
  logic [31:0]    pc_i;
  logic           trap_en_i;
  logic           trap_ack_i;
  logic           trap_clr_i;
  logic [2:0]     cnt_sel_i;
  logic           cnt_clr_i;
  logic           trap_req_o;
  dift_trap_t     trap_cause_o;
  logic [31:0]    trap_pc_o;
  logic           busy_o;
  logic [CW-1:0]  cnt_rdata_o;

  int n_vec  = 0;
  int n_miss = 0;

  vec_t vecs [28];

  always #5 clk = ~clk;

  dift_trap_ctrl #(
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trap_i       (trap_i),
    .trap_type_i  (trap_type_i),
    .pc_i         (pc_i),
    .trap_en_i    (trap_en_i),
    .trap_ack_i   (trap_ack_i),
    .trap_clr_i   (trap_clr_i),
    .cnt_sel_i    (cnt_sel_i),
    .cnt_clr_i    (cnt_clr_i),
    .trap_req_o   (trap_req_o),
    .trap_cause_o (trap_cause_o),
    .trap_pc_o    (trap_pc_o),
    .busy_o       (busy_o),
    .cnt_rdata_o  (cnt_rdata_o)
  );

  function automatic vec_t mk(logic r, logic t, dift_trap_t ty, logic [31:0] p,
                              logic e, logic a, logic c, logic [2:0] s, logic cc,
                              logic xr, dift_trap_t xc, logic [31:0] xp,
                              logic xb, logic [CW-1:0] xn);
    vec_t v;
    v.rst = r; v.trap = t; v.ttype = ty; v.pc = p; v.en = e; v.ack = a;
    v.clr = c; v.sel = s; v.cclr = cc;
    v.e_req = xr; v.e_cause = xc; v.e_pc = xp; v.e_busy = xb; v.e_cnt = xn;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst         = v.rst;
    trap_i      = v.trap;
    trap_type_i = v.ttype;
    pc_i        = v.pc;
    trap_en_i   = v.en;
    trap_ack_i  = v.ack;
    trap_clr_i  = v.clr;
    cnt_sel_i   = v.sel;
    cnt_clr_i   = v.cclr;
  endtask

  task automatic check(input string name, input vec_t v);
    n_vec++;
    if (trap_req_o !== v.e_req) begin
      n_miss++;
      $display("FAIL %s req: got %0b want %0b", name, trap_req_o, v.e_req);
    end
    if (trap_cause_o !== v.e_cause) begin
      n_miss++;
      $display("FAIL %s cause: got %0d want %0d", name, trap_cause_o, v.e_cause);
    end
    if (trap_pc_o !== v.e_pc) begin
      n_miss++;
      $display("FAIL %s pc: got %h want %h", name, trap_pc_o, v.e_pc);
    end
    if (busy_o !== v.e_busy) begin
      n_miss++;
      $display("FAIL %s busy: got %0b want %0b", name, busy_o, v.e_busy);
    end
    if (cnt_rdata_o !== v.e_cnt) begin
      n_miss++;
      $display("FAIL %s cnt(sel=%0d): got %0d want %0d", name, cnt_sel_i, cnt_rdata_o, v.e_cnt);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check(name, v);
  endtask

  initial begin
    vec_t v;
    //              rst trap type  pc          en ack clr sel cclr | req cause pc        busy cnt
    vecs[0]  = mk(1, 0, NONE, 32'h0,    1, 0, 0, 3'd0, 0,  0, NONE, 32'h0,    0, 4'd0);
    // basic raise, ack three cycles later, clear
    vecs[1]  = mk(0, 1, LOAD, 32'h1234, 1, 0, 0, 3'd5, 0,  1, LOAD, 32'h1234, 1, 4'd1);
    vecs[2]  = mk(0, 0, NONE, 32'h0,    1, 0, 0, 3'd5, 0,  1, LOAD, 32'h1234, 1, 4'd1);
    vecs[3]  = mk(0, 0, NONE, 32'h0,    1, 0, 0, 3'd5, 0,  1, LOAD, 32'h1234, 1, 4'd1);
    vecs[4]  = mk(0, 0, NONE, 32'h0,    1, 1, 0, 3'd5, 0,  0, LOAD, 32'h1234, 1, 4'd1);
    vecs[5]  = mk(0, 0, NONE, 32'h0,    1, 0, 1, 3'd5, 0,  0, LOAD, 32'h1234, 0, 4'd1);
    // log-only
    vecs[6]  = mk(0, 1, STOR, 32'h100,  0, 0, 0, 3'd4, 0,  0, LOAD, 32'h1234, 0, 4'd1);
    vecs[7]  = mk(0, 1, STOR, 32'h104,  0, 0, 0, 3'd4, 0,  0, LOAD, 32'h1234, 0, 4'd2);
    vecs[8]  = mk(0, 1, EXEC, 32'h108,  0, 0, 0, 3'd4, 0,  0, LOAD, 32'h1234, 0, 4'd2);
    vecs[9]  = mk(0, 1, STOR, 32'h10c,  0, 0, 0, 3'd4, 0,  0, LOAD, 32'h1234, 0, 4'd3);
    vecs[10] = mk(0, 0, NONE, 32'h0,    0, 0, 0, 3'd1, 0,  0, LOAD, 32'h1234, 0, 4'd1);
    vecs[11] = mk(0, 0, NONE, 32'h0,    0, 0, 0, 3'd0, 0,  0, LOAD, 32'h1234, 0, 4'd0);
    // drops in REQ / HANDLER / on the clear cycle
    vecs[12] = mk(0, 1, JALR, 32'h2000, 1, 0, 0, 3'd2, 0,  1, JALR, 32'h2000, 1, 4'd1);
    vecs[13] = mk(0, 1, BRAN, 32'h2004, 1, 0, 0, 3'd0, 0,  1, JALR, 32'h2000, 1, 4'd1);
    vecs[14] = mk(0, 1, BRAN, 32'h2008, 1, 0, 0, 3'd0, 0,  1, JALR, 32'h2000, 1, 4'd2);
    vecs[15] = mk(0, 0, NONE, 32'h0,    1, 1, 0, 3'd3, 0,  0, JALR, 32'h2000, 1, 4'd2);
    vecs[16] = mk(0, 1, BRAN, 32'h200c, 1, 0, 0, 3'd0, 0,  0, JALR, 32'h2000, 1, 4'd3);
    vecs[17] = mk(0, 1, BRAN, 32'h2010, 1, 0, 1, 3'd0, 0,  0, JALR, 32'h2000, 0, 4'd4);
    vecs[18] = mk(0, 0, NONE, 32'h0,    1, 0, 0, 3'd3, 0,  0, JALR, 32'h2000, 0, 4'd4);
    vecs[19] = mk(0, 0, NONE, 32'h0,    1, 0, 0, 3'd2, 0,  0, JALR, 32'h2000, 0, 4'd1);
    // ack held high into the first REQ cycle
    vecs[20] = mk(0, 1, EXEC, 32'h3000, 1, 1, 0, 3'd1, 0,  1, EXEC, 32'h3000, 1, 4'd2);
    vecs[21] = mk(0, 0, NONE, 32'h0,    1, 1, 0, 3'd1, 0,  0, EXEC, 32'h3000, 1, 4'd2);
    vecs[22] = mk(0, 0, NONE, 32'h0,    1, 0, 1, 3'd1, 0,  0, EXEC, 32'h3000, 0, 4'd2);
    // abort from REQ keeps cause/PC, then immediate re-raise
    vecs[23] = mk(0, 1, STOR, 32'h4000, 1, 0, 0, 3'd4, 0,  1, STOR, 32'h4000, 1, 4'd4);
    vecs[24] = mk(0, 0, NONE, 32'h0,    1, 0, 1, 3'd4, 0,  0, STOR, 32'h4000, 0, 4'd4);
    vecs[25] = mk(0, 1, LOAD, 32'h5000, 1, 0, 0, 3'd5, 0,  1, LOAD, 32'h5000, 1, 4'd2);
    // reset while in REQ
    vecs[26] = mk(1, 0, NONE, 32'h0,    1, 0, 0, 3'd5, 0,  0, NONE, 32'h0,    0, 4'd0);
    vecs[27] = mk(0, 0, NONE, 32'h0,    1, 0, 0, 3'd4, 0,  0, NONE, 32'h0,    0, 4'd0);

    for (int i = 0; i < 28; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // saturation: 20 EXEC events in log-only mode
    for (int i = 0; i < 20; i++) begin
      v = mk(0, 1, EXEC, 32'h600 + 32'(i), 0, 0, 0, 3'd1, 0, 0, NONE, 32'h0, 0, 4'd0);
      drive(v);
    end
    v = mk(0, 0, NONE, 32'h0, 0, 0, 0, 3'd1, 0, 0, NONE, 32'h0, 0, 4'd15);
    apply("sat15", v);

    // clear coinciding with an event wins
    v = mk(0, 1, EXEC, 32'h700, 0, 0, 0, 3'd1, 1, 0, NONE, 32'h0, 0, 4'd0);
    apply("clr_vs_inc", v);
    v = mk(0, 1, EXEC, 32'h704, 0, 0, 0, 3'd1, 0, 0, NONE, 32'h0, 0, 4'd1);
    apply("inc_after_clr", v);
    v = mk(0, 0, NONE, 32'h0, 0, 0, 0, 3'd6, 0, 0, NONE, 32'h0, 0, 4'd0);
    apply("sel6", v);

    // no combinational path from trap_i to trap_req_o
    v = mk(0, 1, LOAD, 32'h8000, 1, 0, 0, 3'd5, 0, 0, NONE, 32'h0, 0, 4'd0);
    drive(v);
    #1;
    check("comb_path", v);
    @(posedge clk);
    #1;
    v.e_req = 1; v.e_cause = LOAD; v.e_pc = 32'h8000; v.e_busy = 1; v.e_cnt = 4'd1;
    check("comb_path_edge", v);

    // stray ack/clear in HANDLER-free IDLE are ignored
    v = mk(0, 0, NONE, 32'h0, 1, 0, 1, 3'd7, 0, 0, LOAD, 32'h8000, 0, 4'd0);
    apply("abort2", v);
    v = mk(0, 0, NONE, 32'h0, 1, 1, 1, 3'd5, 0, 0, LOAD, 32'h8000, 0, 4'd1);
    apply("idle_ack_clr", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
